// File: rtl/cpu_pkg.sv
// Shared types and constants for the unified memory arbiter.
package cpu_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;
  localparam int STREAK_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

endpackage

// File: rtl/arb_priority_sel.sv
// Grant selection between fetch and data ports, with a D-streak counter
// that forces an I grant after MAX_D_STREAK data grants while I waits.
module arb_priority_sel
  import cpu_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic grant_i,
  output logic grant_d
);

  logic [STREAK_W-1:0] streak_reg;
  logic [STREAK_W-1:0] streak_next;
  logic                force_i;

  assign force_i = (streak_reg == STREAK_W'(MAX_D_STREAK));

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (arb_en) begin
      if (i_req && (!d_req || force_i)) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  // Only D grants made while I is waiting extend the streak.
  always_comb begin
    streak_next = streak_reg;
    if (grant_i) begin
      streak_next = '0;
    end else if (grant_d) begin
      if (!i_req) begin
        streak_next = '0;
      end else if (!force_i) begin
        streak_next = streak_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_reg <= '0;
    end else begin
      streak_reg <= streak_next;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between fetch (I) and data (D) ports.
// Optional performance counters are built when ARB_PERF_CNT_EN is defined.
module unified_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_dout,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_din,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_dout,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [31:0]       perf_i_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_stall_cycles
);

  arb_state_t state_reg;
  logic       owner_reg;
  logic       grant_i;
  logic       grant_d;

  arb_priority_sel #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_sel (
    .clk    (clk),
    .reset  (reset),
    .arb_en (state_reg == IDLE),
    .i_req  (i_req),
    .d_req  (d_req),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );

  // mem_* fields double as the latched request: they are loaded on the
  // grant and held untouched until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      owner_reg     <= OWNER_I;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_din       <= '0;
      i_ready       <= 1'b0;
      d_ready       <= 1'b0;
      i_dout        <= '0;
      d_dout        <= '0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_d) begin
            owner_reg     <= OWNER_D;
            mem_we        <= d_we;
            mem_addr      <= d_addr;
            mem_din       <= d_din;
            mem_req_valid <= 1'b1;
            state_reg     <= ISSUE;
          end else if (grant_i) begin
            owner_reg     <= OWNER_I;
            mem_we        <= 1'b0;
            mem_addr      <= i_addr;
            mem_din       <= '0;
            mem_req_valid <= 1'b1;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            if (owner_reg == OWNER_D) begin
              // A store ack carries no data worth keeping.
              if (!mem_we) begin
                d_dout <= mem_dout;
              end
              d_ready <= 1'b1;
            end else begin
              i_dout  <= mem_dout;
              i_ready <= 1'b1;
            end
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_i_reg;
  logic [31:0] perf_d_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_i_reg     <= '0;
      perf_d_reg     <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (grant_i) begin
        perf_i_reg <= perf_i_reg + 32'd1;
      end
      if (grant_d) begin
        perf_d_reg <= perf_d_reg + 32'd1;
      end
      if ((i_req && !i_ready) || (d_req && !d_ready)) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
    end
  end

  assign perf_i_grants     = perf_i_reg;
  assign perf_d_grants     = perf_d_reg;
  assign perf_stall_cycles = perf_stall_reg;
`else
  assign perf_i_grants     = '0;
  assign perf_d_grants     = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: vector table, corner-case
// sequences and a randomized run against a transaction-level memory model.
module tb_unified_mem_arbiter;
  import cpu_pkg::*;

  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_dout;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_din;
  logic        d_ready;
  logic [31:0] d_dout;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_resp_valid;
  logic [31:0] mem_dout;
  logic [31:0] perf_i_grants;
  logic [31:0] perf_d_grants;
  logic [31:0] perf_stall_cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_D_STREAK(MAXS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_req            (i_req),
    .i_addr           (i_addr),
    .i_ready          (i_ready),
    .i_dout           (i_dout),
    .d_req            (d_req),
    .d_we             (d_we),
    .d_addr           (d_addr),
    .d_din            (d_din),
    .d_ready          (d_ready),
    .d_dout           (d_dout),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_din          (mem_din),
    .mem_resp_valid   (mem_resp_valid),
    .mem_dout         (mem_dout),
    .perf_i_grants    (perf_i_grants),
    .perf_d_grants    (perf_d_grants),
    .perf_stall_cycles(perf_stall_cycles)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem_arr [0:255];
  int  accept_delay = 0;
  int  resp_delay   = 0;
  bit  rand_mem     = 0;
  bit  pend         = 0;
  int  wcnt         = 0;
  int  rcnt         = 0;
  logic [31:0] p_addr;
  logic [31:0] p_din;
  logic        p_we;

  initial begin
    for (int k = 0; k < 256; k++) mem_arr[k] = 32'h1000_0000 + 32'(k * 7);
    mem_arr[16] = 32'h00A0_0093;
    mem_arr[64] = 32'hDEAD_BEEF;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_dout       = '0;
    p_addr = '0; p_din = '0; p_we = 1'b0;
    forever begin
      tick();
      mem_resp_valid = 1'b0;
      if (mem_req_ready) begin
        mem_req_ready = 1'b0;
        pend = 1; rcnt = 0; wcnt = 0;
        if (rand_mem) resp_delay = $urandom_range(0, 2);
      end
      if (pend) begin
        if (rcnt >= resp_delay) begin
          mem_resp_valid = 1'b1;
          if (p_we) begin
            mem_arr[p_addr[9:2]] = p_din;
            mem_dout = $urandom;
          end else begin
            mem_dout = mem_arr[p_addr[9:2]];
          end
          pend = 0;
          if (rand_mem) accept_delay = $urandom_range(0, 3);
        end else begin
          rcnt++;
        end
      end else if (mem_req_valid) begin
        if (wcnt >= accept_delay) begin
          mem_req_ready = 1'b1;
          p_addr = mem_addr; p_we = mem_we; p_din = mem_din;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // ---------------- reference model for random phase ----------------
  logic [31:0] ref_mem [0:255];
  logic [31:0] d_last;

  task automatic i_driver(input int n);
    for (int k = 0; k < n; k++) begin
      int gap;
      int seen_d;
      bit got;
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      i_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      i_req  = 1'b1;
      seen_d = 0; got = 0;
      for (int c = 0; c < 300 && !got; c++) begin
        tick();
        if (d_ready) seen_d++;
        if (i_ready) got = 1;
      end
      if (!got) begin
        check("rand i timeout", 32'd0, 32'd1);
        i_req = 1'b0;
        return;
      end
      check("rand i_dout", i_dout, ref_mem[i_addr[9:2]]);
      check("rand i starvation", 32'(seen_d <= MAXS + 1), 32'd1);
      $display("txn I addr=%h data=%h d_served_while_waiting=%0d", i_addr, i_dout, seen_d);
      i_req = 1'b0;
    end
  endtask

  task automatic d_driver(input int n);
    for (int k = 0; k < n; k++) begin
      int gap;
      bit got;
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      d_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      d_we   = 1'($urandom_range(0, 1));
      d_din  = $urandom;
      d_req  = 1'b1;
      got = 0;
      for (int c = 0; c < 300 && !got; c++) begin
        tick();
        if (d_ready) got = 1;
      end
      if (!got) begin
        check("rand d timeout", 32'd0, 32'd1);
        d_req = 1'b0;
        return;
      end
      if (d_we) begin
        ref_mem[d_addr[9:2]] = d_din;
        check("rand store d_dout hold", d_dout, d_last);
      end else begin
        d_last = ref_mem[d_addr[9:2]];
        check("rand load d_dout", d_dout, d_last);
      end
      $display("txn D we=%0d addr=%h wdata=%h dout=%h", d_we, d_addr, d_din, d_dout);
      d_req = 1'b0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pi0, pd0, ps0;
    logic [31:0] old_d;
    string       order;
    string       exp_order;
    int          lat;
    int          vcnt;
    bit          got;
    bit          other;

    vecs[0] = '{is_d: 0, we: 0, addr: 32'h40,  din: 32'h0,         exp_dout: 32'h00A0_0093, exp_lat: 3};
    vecs[1] = '{is_d: 1, we: 0, addr: 32'h100, din: 32'h0,         exp_dout: 32'hDEAD_BEEF, exp_lat: 3};
    vecs[2] = '{is_d: 1, we: 1, addr: 32'h80,  din: 32'hCAFE_F00D, exp_dout: 32'hDEAD_BEEF, exp_lat: 3};
    vecs[3] = '{is_d: 1, we: 0, addr: 32'h80,  din: 32'h0,         exp_dout: 32'hCAFE_F00D, exp_lat: 3};
    vecs[4] = '{is_d: 0, we: 0, addr: 32'h80,  din: 32'h0,         exp_dout: 32'hCAFE_F00D, exp_lat: 3};

    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_din = '0;
    repeat (3) tick();
    reset = 1'b0;

    check("reset i_ready", 32'(i_ready), 32'd0);
    check("reset d_ready", 32'(d_ready), 32'd0);
    check("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_din", mem_din, 32'd0);
    check("reset i_dout", i_dout, 32'd0);
    check("reset d_dout", d_dout, 32'd0);
    check("reset perf_i", perf_i_grants, 32'd0);
    check("reset perf_d", perf_d_grants, 32'd0);
    check("reset perf_stall", perf_stall_cycles, 32'd0);

    // single-port transactions from an idle arbiter
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].is_d) begin
        d_req = 1'b1; d_we = vecs[v].we; d_addr = vecs[v].addr; d_din = vecs[v].din;
      end else begin
        i_req = 1'b1; i_addr = vecs[v].addr;
      end
      lat = 0; got = 0; other = 0;
      while (!got && lat < 50) begin
        tick();
        lat++;
        if (vecs[v].is_d ? d_ready : i_ready) got = 1;
        else if (vecs[v].is_d ? i_ready : d_ready) other = 1;
      end
      check($sformatf("vec%0d latency", v), 32'(lat), 32'(vecs[v].exp_lat));
      check($sformatf("vec%0d dout", v), vecs[v].is_d ? d_dout : i_dout, vecs[v].exp_dout);
      check($sformatf("vec%0d other ready", v), 32'(other), 32'd0);
      $display("txn vec%0d port=%s addr=%h latency=%0d", v, vecs[v].is_d ? "D" : "I", vecs[v].addr, lat);
      i_req = 1'b0; d_req = 1'b0;
      tick();
    end

    // simultaneous I fetch and D load: D first, I follows
    pi0 = perf_i_grants; pd0 = perf_d_grants; ps0 = perf_stall_cycles;
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    lat = 0; got = 0;
    while (!got && lat < 50) begin
      tick(); lat++;
      if (d_ready) begin
        check("both d_ready cycle", 32'(lat), 32'd3);
        check("both d_dout", d_dout, 32'hDEAD_BEEF);
        d_req = 1'b0;
      end
      if (i_ready) begin
        got = 1;
        check("both i_ready cycle", 32'(lat), 32'd7);
        check("both i_dout", i_dout, 32'h00A0_0093);
        i_req = 1'b0;
      end
    end
    if (!got) check("both i timeout", 32'd0, 32'd1);
    tick();
`ifdef ARB_PERF_CNT_EN
    check("perf d grants", perf_d_grants - pd0, 32'd1);
    check("perf i grants", perf_i_grants - pi0, 32'd1);
    check("perf stall cycles", perf_stall_cycles - ps0, 32'd7);
`else
    check("perf d grants", perf_d_grants, 32'd0);
    check("perf i grants", perf_i_grants, 32'd0);
    check("perf stall cycles", perf_stall_cycles, 32'd0);
`endif
    $display("txn both-ports i_lat=%0d", lat);

    // starvation: D held continuously while I waits
    order = "";
    exp_order = "DDDDID";
    i_req = 1'b1; i_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int c = 0; c < 200 && order.len() < 6; c++) begin
      tick();
      if (d_ready) begin
        order = {order, "D"};
        if (order.len() == 6) d_req = 1'b0;
      end
      if (i_ready) begin
        order = {order, "I"};
        check("streak after I grant", 32'(dut.u_sel.streak_reg), 32'd0);
        i_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    check("starvation count", 32'(order.len()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      logic [7:0] got_c;
      got_c = (k < order.len()) ? order[k] : 8'h2E;
      check($sformatf("grant order %0d", k), 32'(got_c), 32'(exp_order[k]));
    end
    $display("txn starvation order=%s", order);
    tick();

    // backpressure on a store
    accept_delay = 3;
    old_d = 32'hDEAD_BEEF;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_din = 32'h1234_5678;
    lat = 0; got = 0; vcnt = 0;
    while (!got && lat < 50) begin
      tick(); lat++;
      if (mem_req_valid) begin
        vcnt++;
        check("bp mem_addr", mem_addr, 32'h200);
        check("bp mem_we", 32'(mem_we), 32'd1);
        check("bp mem_din", mem_din, 32'h1234_5678);
      end
      if (d_ready) got = 1;
    end
    d_req = 1'b0;
    accept_delay = 0;
    check("bp valid cycles", 32'(vcnt), 32'd4);
    check("bp ready cycle", 32'(lat), 32'd6);
    check("bp d_dout hold", d_dout, old_d);
    check("bp memory written", mem_arr[128], 32'h1234_5678);
    $display("txn backpressure store latency=%0d valid_cycles=%0d", lat, vcnt);
    tick();

    // reset while waiting for the response, then a late response
    resp_delay = 3;
    i_req = 1'b1; i_addr = 32'h40;
    tick();  // ISSUE
    tick();  // WAIT
    check("pre-reset in WAIT", 32'(dut.state_reg), 32'(WAIT));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    i_req = 1'b0;
    check("post-reset i_dout", i_dout, 32'd0);
    got = 0;
    for (int c = 0; c < 6; c++) begin
      if (i_ready || d_ready) got = 1;
      check("post-reset mem_req_valid", 32'(mem_req_valid), 32'd0);
      check("post-reset state", 32'(dut.state_reg), 32'(IDLE));
      tick();
    end
    check("post-reset no ready", 32'(got), 32'd0);
    resp_delay = 0;
    $display("txn reset-in-wait");

    // randomized concurrent traffic
    for (int k = 0; k < 256; k++) ref_mem[k] = mem_arr[k];
    d_last = 32'd0;
    rand_mem = 1;
    fork
      i_driver(40);
      d_driver(40);
    join
    rand_mem = 0;
    repeat (10) tick();
    accept_delay = 0;
    resp_delay = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between the pipeline's instruction-fetch port (I) and data-access port (D).
- Sits between the cpu IF/MEM stages and the memory model.
- Sequences each access through a request/accept/response handshake.
- Pulses a one-cycle ready back to the winning requester; the cpu stalls on !ready.

Parameters:
- ADDR_W, 32, address width in bits
- DATA_W, 32, data width in bits
- MAX_D_STREAK, 4, consecutive D grants allowed while I is pending before I is forced (range 1..15)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- i_req  input  1  fetch request; held with i_addr stable until i_ready
- i_addr  input  ADDR_W  fetch address
- i_ready  output  1  one-cycle pulse; i_dout valid this cycle
- i_dout  output  DATA_W  fetched word
- d_req  input  1  data request; held with d_we/d_addr/d_din stable until d_ready
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_W  data address
- d_din  input  DATA_W  store data
- d_ready  output  1  one-cycle pulse; d_dout valid for loads
- d_dout  output  DATA_W  load data
- mem_req_valid  output  1  request to memory
- mem_req_ready  input  1  memory accepts the request this cycle
- mem_we  output  1  write enable
- mem_addr  output  ADDR_W  address to memory
- mem_din  output  DATA_W  write data
- mem_resp_valid  input  1  response/ack, one cycle, for loads and stores
- mem_dout  input  DATA_W  read data
- perf_i_grants  output  32  see Optional Feature
- perf_d_grants  output  32  see Optional Feature
- perf_stall_cycles  output  32  see Optional Feature

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: FSM=IDLE, owner=I, streak=0; all outputs 0 (i_ready, d_ready, mem_req_valid, mem_we, mem_addr, mem_din, i_dout, d_dout, perf_*).
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: arbitrate on i_req/d_req.
  - D wins by default.
  - I wins if only i_req is set, or if i_req && d_req && streak==MAX_D_STREAK.
  - On a grant, latch owner, addr, we (0 for I), din, then go to ISSUE.
  - In IDLE, mem_resp_valid is ignored.
- ISSUE: mem_req_valid=1 with the latched fields. Stay until mem_req_ready, then go to WAIT; mem_req_valid drops the next cycle.
- WAIT: on mem_resp_valid, register mem_dout into the owner's dout, then go to DONE.
- DONE: owner's ready=1 for exactly this cycle, then go to IDLE. A store's d_dout is unchanged.
- Minimum latency (memory ready immediately, response the cycle after accept): req seen at T0 → mem_req_valid at T1 → resp at T2 → ready at T3 → next arbitration at T4.
- Requesters update req on the edge ending DONE, so no double service.
- Streak counter (4 bits):
  - Increments on a D grant while i_req is high, saturating at MAX_D_STREAK.
  - Clears on any I grant, and on any D grant with i_req low.
- dout registers hold their value until the next response for the same port.
- Reset mid-operation (any state): immediately go to IDLE with outputs at reset values. A late mem_resp_valid after reset is dropped. Memory must tolerate an abandoned request.
- Requests are never reordered; only one access is outstanding at a time.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - perf_i_grants and perf_d_grants increment on each I/D grant in IDLE.
  - perf_stall_cycles increments each cycle that (i_req && !i_ready) || (d_req && !d_ready).
  - All three wrap at 2^32 and clear on reset.
- Undefined: the three ports remain and are tied to 0; no counter flops are synthesized.

Decomposition:
- Shared package cpu_pkg:
  - arb_state_t enum (IDLE, ISSUE, WAIT, DONE)
  - owner encoding constants OWNER_I=1'b0, OWNER_D=1'b1
  - ADDR_W/DATA_W defaults
- One natural sub-module: arb_priority_sel, the combinational grant logic plus the streak counter (inputs i_req, d_req; outputs grant_i, grant_d).
- FSM and datapath latches stay in the top module.

Test Plan:
- I only: i_req=1, i_addr=0x40, mem ready immediately, mem_dout=0x00A00093 at T2 → i_ready pulses at T3 with i_dout=0x00A00093; d_ready stays 0.
- Simultaneous I and D load: d_addr=0x100 returns 0xDEADBEEF → D served first (d_ready at T3); I is granted at T4 and its i_ready arrives at T7.
- Starvation: d_req held high over 5 back-to-back accesses with i_req=1, MAX_D_STREAK=4 → grant order D,D,D,D,I,D; streak reads 0 after the I grant.
- Memory backpressure: mem_req_ready low for 3 cycles, store d_we=1, d_addr=0x200, d_din=0x12345678 → mem_req_valid and fields held stable for 4 cycles; d_ready one cycle after the ack; d_dout unchanged.
- Reset in WAIT: assert reset for 1 cycle, then deliver mem_resp_valid → no ready pulse; FSM in IDLE; mem_req_valid=0.
- ARB_PERF_CNT_EN defined, run scenario 2 → perf_d_grants=1, perf_i_grants=1, perf_stall_cycles=7. Undefined → all three stay 0.
